instruction_fetch_unit: RTL and testbench

//  Parametrised fetch stage for the RV64 datapath. Holds the PC, reads a word-indexed instruction

---
 rtl/instruction_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage for the RV64 datapath. Holds the PC, reads a word-indexed
//   instruction memory combinationally, and queues {pc, inst, pc+4, fault}
//   into a small prefetch FIFO that drains to decode over valid/ready.
//   A redirect flushes the FIFO and restarts fetch at a new PC. A misaligned
//   or out-of-range fetch enqueues a single NOP entry marked as a fault and
//   halts fetching until the next redirect.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   redirect_valid/pc flush and restart fetch at redirect_pc
//   imem_we/waddr/    synchronous instruction-memory write port (program load)
//   imem_wdata
//   out_valid/ready   head-of-FIFO handshake towards decode
//   out_pc/inst/pc4/  head entry fields, all zero while the FIFO is empty
//   out_fault
//   fifo_count        number of occupied FIFO entries
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter int              IMEM_WORDS = 64,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            redirect_valid,
  input  logic [XLEN-1:0]                 redirect_pc,
  input  logic                            imem_we,
  input  logic [XLEN-1:0]                 imem_waddr,
  input  logic [31:0]                     imem_wdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_pc,
  output logic [31:0]                     out_inst,
  output logic [XLEN-1:0]                 out_pc4,
  output logic                            out_fault,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc4;
    logic            fault;
  } entry_t;

  // Architectural state
  logic [XLEN-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Storage arrays
  entry_t          fifo_q [FIFO_DEPTH];
  logic [31:0]     mem_q  [IMEM_WORDS];

  // Fetch-side combinational signals
  logic            fetch_fault;
  logic [31:0]     fetch_word;
  logic            pop;
  logic            push;
  entry_t          new_entry;
  entry_t          head;

  // Byte-offset bits of the write address do not select anything.
  logic            unused_waddr_lsbs;
  assign unused_waddr_lsbs = ^imem_waddr[1:0];

  // Faulting fetch: misaligned, or word index beyond the memory depth.
  assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q[XLEN-1:AW+2] != '0);
  assign fetch_word  = mem_q[pc_q[AW+1:2]];

  assign pop  = (count_q != '0) && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push = !redirect_valid && !halted_q && ((count_q != FULL_COUNT) || pop);

  assign new_entry = '{pc:    pc_q,
                       inst:  fetch_fault ? NOP_INST : fetch_word,
                       pc4:   pc_q + XLEN'(4),
                       fault: fetch_fault};

  // Next-state logic; redirect overrides both push and pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pc_d     = pc_q;
    halted_d = halted_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (fetch_fault) halted_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the FIFO payload and the instruction memory carry no reset; the
  // FIFO is emptied through its count and the memory must survive reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  // Out-of-range writes are dropped instead of aliasing onto low words.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_waddr[XLEN-1:AW+2] == '0)) begin
      mem_q[imem_waddr[AW+1:2]] <= imem_wdata;
    end
  end

  // Outputs come from the head entry and are forced to zero when empty,
  // so an asynchronous reset clears them immediately via count_q.
  assign head       = fifo_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? head.pc    : '0;
  assign out_inst   = out_valid ? head.inst  : '0;
  assign out_pc4    = out_valid ? head.pc4   : '0;
  assign out_fault  = out_valid ? head.fault : 1'b0;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed, table-driven bench for instruction_fetch_unit with the default
//   parameters (XLEN=64, IMEM_WORDS=64, FIFO_DEPTH=4, RESET_PC=0). Each table
//   row holds the inputs for one clock edge and the expected head state after
//   it; instruction words come from a bench-side image of the program.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int XLEN = 64;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_we = 1'b0;
  logic [XLEN-1:0] imem_waddr = '0;
  logic [31:0]     imem_wdata = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc4;
  logic            out_fault;
  logic [CW-1:0]   fifo_count;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_pc4        (out_pc4),
    .out_fault      (out_fault),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [64];

  typedef struct {
    logic            rst;
    logic            redir;
    logic [XLEN-1:0] rpc;
    logic            rdy;
    logic            ev;
    logic [XLEN-1:0] epc;
    logic            ef;
    logic [CW-1:0]   ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic redir, input logic [XLEN-1:0] rpc,
                              input logic rdy, input logic ev, input logic [XLEN-1:0] epc,
                              input logic ef, input logic [CW-1:0] ec);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected head fields derive from valid/pc/fault plus the program image.
  task automatic check_head(input string tag, input logic ev, input logic [XLEN-1:0] epc,
                            input logic ef, input logic [CW-1:0] ec);
    logic [XLEN-1:0] x_pc, x_pc4;
    logic [31:0]     x_inst;
    logic            x_fault;
    x_pc    = ev ? epc : '0;
    x_pc4   = ev ? epc + 64'd4 : '0;
    x_fault = ev ? ef : 1'b0;
    x_inst  = !ev ? 32'h0 : (ef ? 32'h0000_0013 : model_mem[epc[7:2]]);
    check({tag, ".valid"}, {63'b0, out_valid}, {63'b0, ev});
    check({tag, ".pc"},    out_pc,  x_pc);
    check({tag, ".inst"},  {32'b0, out_inst}, {32'b0, x_inst});
    check({tag, ".pc4"},   out_pc4, x_pc4);
    check({tag, ".fault"}, {63'b0, out_fault}, {63'b0, x_fault});
    check({tag, ".count"}, {61'b0, fifo_count}, {61'b0, ec});
  endtask

  task automatic mem_write(input logic [XLEN-1:0] addr, input logic [31:0] data);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- vector table ----------------
    // T1 + T3: streaming with out_ready=1, then redirect to 0x20 at head pc=8
    add(0, 0, 64'h0,  1,  0, 64'h0,  0, 0);
    add(1, 0, 64'h0,  1,  1, 64'h0,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'h4,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'h8,  0, 1);
    add(1, 1, 64'h20, 1,  0, 64'h0,  0, 0);
    add(1, 0, 64'h0,  1,  1, 64'h20, 0, 1);
    add(1, 0, 64'h0,  1,  1, 64'h24, 0, 1);
    // T4: misaligned redirect -> single fault entry, halt, then recover
    add(1, 1, 64'h22, 1,  0, 64'h0,  0, 0);
    add(1, 0, 64'h0,  0,  1, 64'h22, 1, 1);
    add(1, 0, 64'h0,  0,  1, 64'h22, 1, 1);
    add(1, 0, 64'h0,  0,  1, 64'h22, 1, 1);
    add(1, 0, 64'h0,  1,  0, 64'h0,  0, 0);
    add(1, 1, 64'h0,  1,  0, 64'h0,  0, 0);
    add(1, 0, 64'h0,  1,  1, 64'h0,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'h4,  0, 1);
    // T2: back-pressure fills the FIFO, then drain in order with no gaps
    add(0, 0, 64'h0,  0,  0, 64'h0,  0, 0);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 1);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 2);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 3);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 4);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 4);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 4);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 4);
    add(1, 0, 64'h0,  0,  1, 64'h0,  0, 4);
    add(1, 0, 64'h0,  1,  1, 64'h4,  0, 4);
    add(1, 0, 64'h0,  1,  1, 64'h8,  0, 4);
    add(1, 0, 64'h0,  1,  1, 64'hC,  0, 4);
    add(1, 0, 64'h0,  1,  1, 64'h10, 0, 4);
    add(1, 0, 64'h0,  1,  1, 64'h14, 0, 4);
    // T5: run off the end of memory at 0x100
    add(1, 1, 64'hF0, 1,  0, 64'h0,   0, 0);
    add(1, 0, 64'h0,  1,  1, 64'hF0,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'hF4,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'hF8,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'hFC,  0, 1);
    add(1, 0, 64'h0,  1,  1, 64'h100, 1, 1);
    add(1, 0, 64'h0,  1,  0, 64'h0,   0, 0);
    add(1, 0, 64'h0,  1,  0, 64'h0,   0, 0);
    // PC wrap: last word of the address space faults and pc4 wraps to 0
    add(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0,  0, 64'h0, 0, 0);
    add(1, 0, 64'h0, 0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);
    add(1, 0, 64'h0, 0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1);

    // ---------------- program load (held in reset) ----------------
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0A00_0000 | i;
    model_mem[0] = 32'h0031_0233;
    model_mem[1] = 32'h0031_02B3;
    for (int i = 0; i < 64; i++) mem_write(64'(i) << 2, model_mem[i]);
    // Out-of-range writes would alias onto words 0/1 or 63 if not dropped.
    mem_write(64'h100, 32'hDEAD_BEEF);
    mem_write(64'h104, 32'hDEAD_BEEF);
    mem_write(64'hFFFF_FFFF_FFFF_FFFC, 32'hDEAD_BEEF);

    check_head("reset", 1'b0, 64'h0, 1'b0, 3'd0);

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n          = vecs[i].rst;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(posedge clk);
      #1;
      check_head($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].ef, vecs[i].ec);
    end

    // ---------------- T6: asynchronous reset with three entries queued ----
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_head("t6_fill", 1'b1, 64'h0, 1'b0, 3'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_head("t6_async", 1'b0, 64'h0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_head("t6_restart", 1'b1, 64'h0, 1'b0, 3'd1);

    // ---------------- same-cycle write to the word being fetched ----------
    // pc register is 4 here; the fetch of word 1 and its rewrite share an edge.
    @(negedge clk);
    imem_we    = 1'b1;
    imem_waddr = 64'h4;
    imem_wdata = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    check_head("wr_same_cycle", 1'b1, 64'h0, 1'b0, 3'd2);
    @(negedge clk);
    imem_we   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("wr_old_word.pc",   out_pc, 64'h4);
    check("wr_old_word.inst", {32'b0, out_inst}, {32'b0, 32'h0031_02B3});
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4;
    @(posedge clk);
    #1;
    check_head("wr_redirect", 1'b0, 64'h0, 1'b0, 3'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    model_mem[1]   = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    check_head("wr_new_word", 1'b1, 64'h4, 1'b0, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
